// File: rtl/aes_tb_pkg.sv
// Shared types and constants for the AES-128 stimulus/response path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_tb_pkg;

  localparam int AES_KEY_SIZE      = 128;
  localparam int AES_CYCLE_LATENCY = 21;

  // Feedback taps 127, 125, 100, 98; the stimulus lfsr uses the same polynomial,
  // so both sides read it from here and cannot drift apart.
  localparam logic [AES_KEY_SIZE-1:0] LFSR_TAP_MASK =
      (128'd1 << 127) | (128'd1 << 125) | (128'd1 << 100) | (128'd1 << 98);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_COMPACT = 2'd2,
    ST_DONE    = 2'd3
  } misr_state_e;

endpackage

// File: rtl/misr_step.sv
// Next-state function of a multiple-input signature register.
// Latency: combinational.
// Backpressure: none; caller decides when to commit the result.
module misr_step #(
  parameter int W = 128
) (
  input  logic [W-1:0] i_sig,
  input  logic [W-1:0] i_data,
  input  logic [W-1:0] i_mask,
  output logic [W-1:0] o_sig
);

  logic fb;

  // Shift in the parity of the tapped bits, then fold the new data word on top.
  always_comb begin
    fb    = ^(i_sig & i_mask);
    o_sig = {i_sig[W-2:0], fb} ^ i_data;
  end

endmodule

// File: rtl/aes_resp_misr.sv
// AES response compactor: skips pipeline fill, folds N blocks into a MISR, compares to golden.
// Latency: done visible LATENCY+N enabled cycles after start (1 cycle when N=0).
// Backpressure: i_enable=0 freezes counters and signature; i_start ignored while busy.
module aes_resp_misr
  import aes_tb_pkg::*;
#(
  parameter int                   NUM_BITS = AES_KEY_SIZE,
  parameter int                   LATENCY  = AES_CYCLE_LATENCY,
  parameter logic [NUM_BITS-1:0]  TAP_MASK = LFSR_TAP_MASK,
  parameter logic [NUM_BITS-1:0]  SIG_SEED = '0,
  parameter int                   CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [CNT_W-1:0]    i_num_tests,
  input  logic                i_enable,
  input  logic [NUM_BITS-1:0] i_data,
  input  logic [NUM_BITS-1:0] i_expected_sig,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass,
  output logic [NUM_BITS-1:0] o_signature,
  output logic [CNT_W-1:0]    o_count
);

  localparam int FILL_W = $clog2(LATENCY + 1);
  // Fill ends on the enabled edge that moves the counter to LATENCY-1, so the
  // first absorb lands exactly LATENCY enabled edges after the start edge.
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LATENCY - 2);

  misr_state_e          state_q, state_d;
  logic [FILL_W-1:0]    fill_cnt_q, fill_cnt_d;
  logic [NUM_BITS-1:0]  sig_q, sig_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     num_q, num_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;

  logic [NUM_BITS-1:0]  sig_step;
  logic [CNT_W-1:0]     count_inc;

  misr_step #(
    .W (NUM_BITS)
  ) u_misr_step (
    .i_sig  (sig_q),
    .i_data (i_data),
    .i_mask (TAP_MASK),
    .o_sig  (sig_step)
  );

  assign count_inc = count_q + CNT_W'(1);

  // Next-state logic for the run FSM, counters, signature and status flags.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    sig_d      = sig_q;
    count_d    = count_q;
    num_d      = num_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          num_d      = i_num_tests;
          sig_d      = SIG_SEED;
          count_d    = '0;
          fill_cnt_d = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          if (i_num_tests == '0) begin
            // Nothing to absorb: the seed itself is the final signature.
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (SIG_SEED == i_expected_sig);
          end else begin
            state_d = ST_FILL;
            busy_d  = 1'b1;
          end
        end
      end

      ST_FILL: begin
        if (i_enable) begin
          fill_cnt_d = fill_cnt_q + FILL_W'(1);
          if (fill_cnt_q == FILL_LAST) begin
            state_d = ST_COMPACT;
          end
        end
      end

      ST_COMPACT: begin
        if (i_enable) begin
          sig_d   = sig_step;
          count_d = count_inc;
          if (count_inc == num_q) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (sig_step == i_expected_sig);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any run and discards the partial signature.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fill_cnt_q <= '0;
      sig_q      <= SIG_SEED;
      count_q    <= '0;
      num_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      sig_q      <= sig_d;
      count_q    <= count_d;
      num_q      <= num_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_pass      = pass_q;
  assign o_signature = sig_q;
  assign o_count     = count_q;

endmodule
